// File: rtl/dma_bus_pkg.sv
// Shared system-bus constants: bus widths, PIO status bit positions and default
// addresses for the buffered input ports.
package dma_bus_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 16;

   localparam int unsigned ST_OVF   = 7;
   localparam int unsigned ST_EOP   = 6;
   localparam int unsigned ST_FULL  = 5;
   localparam int unsigned ST_EMPTY = 4;

   localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = 16'hFF00;
   localparam int unsigned       DEF_DEPTH     = 8;
   localparam int unsigned       DEF_THRESH    = 4;

   // Status count field is four bits wide; larger fill levels read as 15.
   function automatic logic [3:0] sat_nibble(input logic [6:0] n);
      return (n > 7'd15) ? 4'hF : n[3:0];
   endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with synchronous clear; head entry is readable combinationally.
module io_sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned W     = 8
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             head_c,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;
   logic [CW-1:0] count_nxt;

   // A pop on a full FIFO frees the slot the simultaneous push lands in.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head_c  = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + CW'(1);
      else if (!do_push && do_pop)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/dma_rx_port.sv
// Buffered device-to-bus input port: byte FIFO drained by DMA reads or PIO data
// reads, with a status register, hysteretic DREQ and a data/overflow interrupt.
module dma_rx_port
   import dma_bus_pkg::*;
#(
   parameter int unsigned       DEPTH     = DEF_DEPTH,
   parameter int unsigned       THRESH    = DEF_THRESH,
   parameter logic [ADDR_W-1:0] BASE_ADDR = DEF_BASE_ADDR
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] dev_data,
   input  logic              dev_valid,
   output logic              dev_ready,
   output logic              DREQ,
   input  logic              DACK,
   input  logic              EOP,
   input  logic              AEN,
   input  logic              IOR,
   input  logic              IReady,
   output logic              TReady,
   input  logic [ADDR_W-1:0] Address_Bus,
   inout  wire  [DATA_W-1:0] Data_Bus,
   output logic              irq
);

   localparam int unsigned       CW        = $clog2(DEPTH) + 1;
   localparam logic [ADDR_W-1:0] DATA_ADDR = ADDR_W'(BASE_ADDR + 1);

   logic [DATA_W-1:0] head;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_next;
   logic              full;
   logic              empty;

   logic dma_sel, pio_sel, pio_data, pio_stat, data_rd, drive;
   logic tready_c, push, pop, drop, stat_xfer;
   logic ovf, ovf_next, eop_seen, eop_next, dreq_next;

   logic [DATA_W-1:0] status;
   logic [DATA_W-1:0] bus_data;

   // Bus decode; a sampled Reset releases the bus and blocks any transfer.
   assign dma_sel  = DACK && IOR;
   assign pio_sel  = !AEN && !DACK && IOR &&
                     (Address_Bus == BASE_ADDR || Address_Bus == DATA_ADDR);
   assign pio_data = pio_sel && (Address_Bus == DATA_ADDR);
   assign pio_stat = pio_sel && (Address_Bus == BASE_ADDR);
   assign data_rd  = dma_sel || pio_data;
   assign drive    = (dma_sel || pio_sel) && !Reset;
   assign tready_c = !(data_rd && empty);

   assign pop        = drive && data_rd && IReady && tready_c;
   assign stat_xfer  = drive && pio_stat && IReady;
   assign push       = !Reset && dev_valid && (!full || pop);
   assign drop       = !Reset && dev_valid && full && !pop;
   assign count_next = Reset ? '0 : count + CW'(push) - CW'(pop);

   always_comb begin
      status             = '0;
      status[ST_OVF]     = ovf;
      status[ST_EOP]     = eop_seen;
      status[ST_FULL]    = full;
      status[ST_EMPTY]   = empty;
      status[3:0]        = sat_nibble(7'(count));
   end

   always_comb begin
      bus_data = status;
      if (data_rd)
         bus_data = empty ? '0 : head;
   end

   assign Data_Bus = drive ? bus_data : 'z;
   assign TReady   = drive ? tready_c : 1'bz;

   io_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (DATA_W)
   ) u_fifo (
      .clk    (clk),
      .clr    (Reset),
      .push   (push),
      .pop    (pop),
      .wdata  (dev_data),
      .head_c (head),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );

   // Flag update: a new overflow or EOP outranks a clear in the same cycle.
   always_comb begin
      ovf_next  = ovf;
      eop_next  = eop_seen;
      dreq_next = 1'b0;
      if (stat_xfer)
         ovf_next = 1'b0;
      if (drop)
         ovf_next = 1'b1;
      if ((!empty && count_next == '0) || (stat_xfer && empty))
         eop_next = 1'b0;
      if (EOP)
         eop_next = 1'b1;
      dreq_next = (count_next >= CW'(THRESH) || (DREQ && count_next != '0)) && !eop_next;
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         ovf       <= 1'b0;
         eop_seen  <= 1'b0;
         DREQ      <= 1'b0;
         irq       <= 1'b0;
         dev_ready <= 1'b0;
      end else begin
         ovf       <= ovf_next;
         eop_seen  <= eop_next;
         DREQ      <= dreq_next;
         irq       <= (count_next != '0) || ovf_next;
         dev_ready <= (count_next != CW'(DEPTH));
      end
   end

endmodule

// File: tb/tb_dma_rx_port.sv
// Bench for dma_rx_port: queue-based reference model checked every cycle, directed
// scenarios with hand-derived literals, then randomized bus/device traffic.
module tb_dma_rx_port;
   import dma_bus_pkg::*;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned THRESH = 4;
   localparam logic [15:0] BASE   = 16'hFF00;
   localparam logic [15:0] DADDR  = 16'hFF01;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, dev_valid, dack, eop, aen, ior, iready;
   logic [7:0]  dev_data;
   logic [15:0] addr;
   logic        dev_ready, dreq, irq;
   // Pulls make a released bus read as FF / TReady 0 on any simulator.
   tri1 [7:0]   data_bus;
   tri0         tready;

   dma_rx_port #(
      .DEPTH     (DEPTH),
      .THRESH    (THRESH),
      .BASE_ADDR (BASE)
   ) dut (
      .clk         (clk),
      .Reset       (rst),
      .dev_data    (dev_data),
      .dev_valid   (dev_valid),
      .dev_ready   (dev_ready),
      .DREQ        (dreq),
      .DACK        (dack),
      .EOP         (eop),
      .AEN         (aen),
      .IOR         (ior),
      .IReady      (iready),
      .TReady      (tready),
      .Address_Bus (addr),
      .Data_Bus    (data_bus),
      .irq         (irq)
   );

   logic [7:0] q[$];
   bit         m_ovf, m_eop, m_dreq, m_irq, m_rdy;
   int         checks = 0;
   int         failures = 0;
   logic [7:0] bus_seen;
   logic       tr_seen;

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_status();
      int n = q.size();
      logic [3:0] fld = (n > 15) ? 4'hF : 4'(n);
      return {m_ovf, m_eop, (n == DEPTH), (n == 0), fld};
   endfunction

   task automatic idle();
      rst = 0; dev_valid = 0; dev_data = 8'h00; dack = 0; eop = 0;
      aen = 0; ior = 0; iready = 0; addr = 16'h0000;
   endtask

   // One clock: check bus drive mid-cycle, apply the cycle to the model, check registers.
   task automatic step();
      bit dsel, psel, pdata, drd, sel, popped, stat_done, was_empty, dropped;
      logic [7:0] exp_bus;
      logic       exp_tr;
      int         n;
      @(negedge clk);
      #1;
      dsel  = dack && ior;
      psel  = !aen && !dack && ior && (addr == BASE || addr == DADDR);
      pdata = psel && (addr == DADDR);
      drd   = dsel || pdata;
      sel   = !rst && (dsel || psel);
      if (!sel) begin
         exp_bus = 8'hFF; exp_tr = 1'b0;
      end else if (drd) begin
         if (q.size() == 0) begin exp_bus = 8'h00; exp_tr = 1'b0; end
         else begin exp_bus = q[0]; exp_tr = 1'b1; end
      end else begin
         exp_bus = model_status(); exp_tr = 1'b1;
      end
      bus_seen = data_bus;
      tr_seen  = tready;
      chk8("data_bus", bus_seen, exp_bus);
      chk1("tready", tr_seen, exp_tr);

      @(posedge clk);
      #1;
      if (rst) begin
         q.delete();
         m_ovf = 0; m_eop = 0; m_dreq = 0; m_irq = 0; m_rdy = 0;
      end else begin
         was_empty = (q.size() == 0);
         popped    = sel && drd && iready && !was_empty;
         stat_done = sel && !drd && iready;
         dropped   = 0;
         if (popped) void'(q.pop_front());
         if (dev_valid) begin
            if (q.size() < DEPTH) q.push_back(dev_data);
            else dropped = 1;
         end
         if (dropped) m_ovf = 1;
         else if (stat_done) m_ovf = 0;
         if (eop) m_eop = 1;
         else if ((!was_empty && q.size() == 0) || (stat_done && was_empty)) m_eop = 0;
         n      = q.size();
         m_dreq = (n >= THRESH || (m_dreq && n != 0)) && !m_eop;
         m_irq  = (n != 0) || m_ovf;
         m_rdy  = (n < DEPTH);
      end
      chk1("dreq", dreq, m_dreq);
      chk1("irq", irq, m_irq);
      chk1("dev_ready", dev_ready, m_rdy);
   endtask

   task automatic push_byte(input logic [7:0] b);
      idle(); dev_valid = 1; dev_data = b; step();
   endtask

   task automatic status_read();
      idle(); ior = 1; addr = BASE; iready = 1; step();
   endtask

   initial begin
      idle();
      rst = 1;
      step(); step();
      chk1("reset_dreq", dreq, 1'b0);
      chk1("reset_irq", irq, 1'b0);
      idle(); step();
      chk1("ready_after_reset", dev_ready, 1'b1);

      // Threshold request
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      chk1("dreq_below_thresh", dreq, 1'b0);
      push_byte(8'h44);
      chk1("dreq_at_thresh", dreq, 1'b1);
      status_read();
      chk8("status_thresh", bus_seen, 8'h04);

      // DMA drain
      idle(); dack = 1; ior = 1; iready = 1;
      step(); chk8("dma_b0", bus_seen, 8'h11);
      step(); chk8("dma_b1", bus_seen, 8'h22);
      step(); chk8("dma_b2", bus_seen, 8'h33);
      step(); chk8("dma_b3", bus_seen, 8'h44);
      chk1("dreq_drained", dreq, 1'b0);
      step();
      chk1("dma_empty_tready", tr_seen, 1'b0);
      chk8("dma_empty_data", bus_seen, 8'h00);

      // Overflow
      for (int i = 0; i < 9; i++) begin
         push_byte(8'hA0 + 8'(i));
         if (i == 7) chk1("not_ready_full", dev_ready, 1'b0);
      end
      status_read(); chk8("status_ovf", bus_seen, 8'hA8);
      status_read(); chk8("status_ovf_cleared", bus_seen, 8'h28);

      // Simultaneous push and pop while full
      idle(); dev_valid = 1; dev_data = 8'h99; dack = 1; ior = 1; iready = 1;
      step();
      chk8("full_pushpop_head", bus_seen, 8'hA0);
      status_read(); chk8("full_pushpop_status", bus_seen, 8'h28);

      // EOP abort
      idle(); rst = 1; step();
      for (int i = 0; i < 6; i++) push_byte(8'h50 + 8'(i));
      chk1("dreq_six", dreq, 1'b1);
      idle(); eop = 1; step();
      chk1("dreq_after_eop", dreq, 1'b0);
      status_read(); chk8("status_eop", bus_seen, 8'h46);
      idle(); ior = 1; addr = DADDR; iready = 1;
      for (int i = 0; i < 6; i++) step();
      chk8("pio_last_byte", bus_seen, 8'h55);
      status_read(); chk8("status_eop_cleared", bus_seen, 8'h10);
      chk1("dreq_after_eop_drain", dreq, 1'b0);

      // Mid-transfer reset
      push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
      idle(); dack = 1; ior = 1; iready = 1; rst = 1;
      step();
      chk8("reset_bus_released", bus_seen, 8'hFF);
      chk1("reset_tready_released", tr_seen, 1'b0);
      chk1("reset_mid_dreq", dreq, 1'b0);
      chk1("reset_mid_irq", irq, 1'b0);
      status_read(); chk8("status_after_reset", bus_seen, 8'h10);

      // Randomized traffic, alternating fill-heavy and drain-heavy phases
      for (int i = 0; i < 4000; i++) begin
         bit fill;
         int a;
         fill      = ((i / 150) % 2) == 0;
         rst       = ($urandom_range(0, 299) == 0);
         dev_valid = fill ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
         dev_data  = 8'($urandom);
         dack      = fill ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 4);
         ior       = ($urandom_range(0, 9) < 5);
         aen       = ($urandom_range(0, 9) == 0);
         iready    = ($urandom_range(0, 9) < 7);
         eop       = ($urandom_range(0, 79) == 0);
         a         = $urandom_range(0, 3);
         addr      = (a == 0) ? BASE : (a == 1) ? DADDR : 16'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dma_rx_port.md
Name: dma_rx_port

Overview:
- Buffered input peripheral on the shared system bus, upstream of the DMA controller on one DMA channel.
- Accepts a byte stream from an external device, such as a keyboard, into an internal FIFO.
- Raises DREQ when enough bytes are buffered and drives bytes onto Data_Bus during DMA read cycles.
- Also exposes a status register and a data register for programmed I/O by the MIPS core. It replaces the unbuffered IO instances that currently share one DREQ line.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, 2..64.
- THRESH, 4, buffered-byte count at or above which DREQ asserts; range 1..DEPTH.
- BASE_ADDR, 16'hFF00, PIO status register address; the data register is at BASE_ADDR+1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- dev_data  input  8  byte from the external device.
- dev_valid  input  1  dev_data is valid this cycle.
- dev_ready  output  1  port can accept a byte (FIFO not full).
- DREQ  output  1  DMA request to the controller, registered.
- DACK  input  1  DMA acknowledge for this channel.
- EOP  input  1  end of process from the DMA, single-cycle pulse.
- AEN  input  1  DMA owns the address bus; PIO decode is disabled while high.
- IOR  input  1  I/O read strobe.
- IReady  input  1  bus initiator ready.
- TReady  output  1  target ready, tri-stated (z) when the port is not selected.
- Address_Bus  input  16  system address.
- Data_Bus  inout  8  system data bus, tri-stated (z) when not driving.
- irq  output  1  registered interrupt: data available, or overflow.

Behaviour:
- Reset:
  - FIFO is emptied, count=0.
  - DREQ=0, irq=0, the overflow flag ovf=0, and the done flag eop_seen=0.
  - dev_ready=1 from the cycle after reset deasserts; Data_Bus and TReady are released.
- Device side (write):
  - A byte is pushed at a rising edge when dev_valid && dev_ready.
  - dev_valid while the FIFO is full drops the byte and sets ovf (sticky).
- DMA select: dma_sel = DACK && IOR.
- PIO select: pio_sel = !AEN && !DACK && IOR && (Address_Bus==BASE_ADDR || Address_Bus==BASE_ADDR+1).
- Drive rules:
  - While dma_sel or pio_sel, the port drives Data_Bus and TReady combinationally. Otherwise both are z.
  - TReady=1 when selected, except for a data read (DMA, or PIO data address) with the FIFO empty. In that case TReady=0 and Data_Bus=8'h00.
- Pop:
  - The FIFO pops at the rising edge where (dma_sel, or PIO data read) && IReady && TReady.
  - Data_Bus shows the head byte before the pop.
  - Status reads never pop.
- Status byte: {ovf, eop_seen, full, empty, count[3:0]}. Count saturates at 15 in the field. Reading status clears ovf at that transfer edge.
- DREQ (registered):
  - Next value = (count_next >= THRESH || (DREQ && count_next != 0)) && !eop_seen_next. This hysteresis holds DREQ until the FIFO is drained.
  - With DEPTH=8 and THRESH=4: a push that raises count to 4 gives DREQ=1 on the following cycle.
- EOP:
  - Sets eop_seen and forces DREQ=0 at the next edge.
  - eop_seen clears when the FIFO becomes empty, or on a status read that completes with the FIFO empty.
- Simultaneous push and pop: count is unchanged; both operations occur, including when the FIFO is full (pop frees a slot) and when empty (no pop, TReady=0).
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits; full = (count==DEPTH).
- irq is registered: irq = !empty || ovf.
- Reset mid-transfer wins: the FIFO is discarded, outputs return to their reset values at that edge, and the bus is released combinationally once Reset is sampled. No partial pop occurs.

Decomposition:
- Shared package dma_bus_pkg holds:
  - the bus width constants DATA_W=8 and ADDR_W=16;
  - the status bit positions (ST_OVF=7, ST_EOP=6, ST_FULL=5, ST_EMPTY=4);
  - the default address constants.
- One sub-module, io_sync_fifo (parameters DEPTH and W). It provides push/pop, head data, count, full and empty, with a synchronous clear.
- Bus decode, drive logic and the DREQ/flag register stay in dma_rx_port.

Test Plan:
- Threshold request: after reset, push 0x11,0x22,0x33,0x44 on consecutive cycles → DREQ=0 until the cycle after the 4th push, then DREQ=1; status read shows 8'h04.
- DMA drain: DACK=1, IOR=1, IReady=1 for 4 cycles → Data_Bus shows 0x11,0x22,0x33,0x44 in order with TReady=1; DREQ drops the cycle after count reaches 0; a 5th cycle gives TReady=0 and Data_Bus=0x00.
- Overflow: push 9 bytes with DEPTH=8 and no reads → dev_ready=0 after the 8th, the 9th is dropped, status=8'hA8 (ovf, full, count 8); a second status read gives 8'h28.
- EOP abort: 6 bytes buffered with DREQ=1, pulse EOP → DREQ=0 next cycle and the eop_seen bit is set; after PIO reads of BASE_ADDR+1 empty the FIFO, eop_seen=0 and DREQ stays 0.
- Simultaneous push and pop at full: FIFO full, dev_valid with DMA read in the same cycle → count stays 8, the head byte is delivered, the new byte is accepted, ovf=0.
- Mid-transfer reset: Reset asserted during a DMA read with 3 bytes buffered → at that edge count=0, DREQ=0, irq=0, and Data_Bus/TReady=z while Reset is high.
